// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings for the pipelined data memory
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_SB = 2'b00,
    ST_SH = 2'b01,
    ST_SW = 2'b10
  } store_type_t;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101
  } load_type_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - store byte strobes/alignment and load extract/extend
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        req_write,
  input  logic [1:0]  byte_off,
  input  logic [1:0]  store_type,
  input  logic [2:0]  load_type,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wstrb,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        type_err,
  output logic        misalign
);

  logic [31:0] shifted;
  logic [15:0] half;

  assign shifted = rword >> {byte_off, 3'b000};
  assign half    = byte_off[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    wstrb    = 4'b0000;
    wword    = 32'd0;
    rdata    = 32'd0;
    type_err = 1'b0;
    misalign = 1'b0;
    if (req_write) begin
      // Replicating the data lets the strobe alone pick the target lanes.
      case (store_type)
        ST_SB: begin
          wstrb = 4'b0001 << byte_off;
          wword = {4{wdata[7:0]}};
        end
        ST_SH: begin
          wstrb    = byte_off[1] ? 4'b1100 : 4'b0011;
          wword    = {2{wdata[15:0]}};
          misalign = byte_off[0];
        end
        ST_SW: begin
          wstrb    = 4'b1111;
          wword    = wdata;
          misalign = (byte_off != 2'b00);
        end
        default: type_err = 1'b1;
      endcase
    end else begin
      case (load_type)
        LD_LB:  rdata = {{24{shifted[7]}}, shifted[7:0]};
        LD_LBU: rdata = {24'd0, shifted[7:0]};
        LD_LH: begin
          rdata    = {{16{half[15]}}, half};
          misalign = byte_off[0];
        end
        LD_LHU: begin
          rdata    = {16'd0, half};
          misalign = byte_off[0];
        end
        LD_LW: begin
          rdata    = rword;
          misalign = (byte_off != 2'b00);
        end
        default: type_err = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/dmem_pipelined.sv
// rtl/dmem_pipelined.sv - single-outstanding data memory with 1 or 2 cycle response
module dmem_pipelined
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_store_type,
  input  logic [2:0]  req_load_type,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int     DEPTH     = 2 ** ADDR_W;
  localparam state_t ACC_STATE = (RD_LAT == 2) ? S_WAIT : S_RESP;

  logic [31:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic              accept;
  logic              range_err, type_err, misalign, access_err;
  logic              mem_we;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       rword, wword, ld_data;
  logic [3:0]        wstrb;
  logic [31:0]       rdata_q;
  logic              err_q;

  // rst_n gates ready directly so nothing is accepted while reset is held.
  assign req_ready = rst_n && ((state_q == S_IDLE) || (state_q == S_RESP && rsp_ready));
  assign accept    = req_valid && req_ready;

  assign word_idx   = req_addr[ADDR_W+1:2];
  assign range_err  = (req_addr >> (ADDR_W + 2)) != 32'd0;
  assign access_err = range_err || type_err || misalign;
  assign mem_we     = accept && req_write && !access_err;
  assign rword      = mem[word_idx];

  dmem_lane_align u_lane_align (
    .req_write  (req_write),
    .byte_off   (req_addr[1:0]),
    .store_type (req_store_type),
    .load_type  (req_load_type),
    .wdata      (req_wdata),
    .rword      (rword),
    .wstrb      (wstrb),
    .wword      (wword),
    .rdata      (ld_data),
    .type_err   (type_err),
    .misalign   (misalign)
  );

  // Memory contents survive reset; only the control path is cleared.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[word_idx][b*8 +: 8] <= wword[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = ACC_STATE;
      S_WAIT: state_d = S_RESP;
      S_RESP: begin
        if (rsp_ready) state_d = accept ? ACC_STATE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The result is captured at acceptance and held until the next accept,
  // which can only happen once the current response has been taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (accept) begin
      err_q   <= access_err;
      rdata_q <= (access_err || req_write) ? 32'd0 : ld_data;
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_pipelined.sv
// tb/tb_dmem_pipelined.sv - directed self-checking bench for dmem_pipelined
module tb_dmem_pipelined;

  logic        clk = 1'b0;
  logic        rst_n, rst2_n;
  logic        req_valid, req_valid2;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_store_type;
  logic [2:0]  req_load_type;
  logic [31:0] req_wdata;
  logic        rsp_ready, rsp_ready2;
  logic        req_ready, req_ready2;
  logic        rsp_valid, rsp_valid2;
  logic [31:0] rsp_rdata, rsp_rdata2;
  logic        rsp_err, rsp_err2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dmem_pipelined #(.ADDR_W(10), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_store_type(req_store_type),
    .req_load_type(req_load_type), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_pipelined #(.ADDR_W(10), .RD_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_write(req_write), .req_addr(req_addr), .req_store_type(req_store_type),
    .req_load_type(req_load_type), .req_wdata(req_wdata), .rsp_valid(rsp_valid2),
    .rsp_ready(rsp_ready2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic set_req(input logic wr, input logic [31:0] addr, input logic [1:0] st,
                         input logic [2:0] lt, input logic [31:0] wd);
    req_write      = wr;
    req_addr       = addr;
    req_store_type = st;
    req_load_type  = lt;
    req_wdata      = wd;
  endtask

  // One transaction on the RD_LAT=1 instance with rsp_ready held high.
  task automatic txn(input string tag, input logic wr, input logic [31:0] addr,
                     input logic [1:0] st, input logic [2:0] lt, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_er);
    int n;
    @(negedge clk);
    set_req(wr, addr, st, lt, wd);
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 10);
    check({tag, "_lat"}, 32'(n), 32'd1);
    check({tag, "_rdata"}, rsp_rdata, exp_rd);
    check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_er});
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    req_valid = 1'b0; req_valid2 = 1'b0;
    rsp_ready = 1'b1; rsp_ready2 = 1'b1;
    set_req(1'b0, 32'd0, 2'b10, 3'b010, 32'd0);

    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst_n = 1'b1; rst2_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);

    txn("sw_10", 1'b1, 32'h10, 2'b10, 3'b000, 32'hDEADBEEF, 32'd0, 1'b0);
    txn("lw_10", 1'b0, 32'h10, 2'b00, 3'b010, 32'd0, 32'hDEADBEEF, 1'b0);

    txn("sw_20_clr", 1'b1, 32'h20, 2'b10, 3'b000, 32'd0, 32'd0, 1'b0);
    txn("sb_21", 1'b1, 32'h21, 2'b00, 3'b000, 32'h12345680, 32'd0, 1'b0);
    txn("lb_21", 1'b0, 32'h21, 2'b00, 3'b000, 32'd0, 32'hFFFFFF80, 1'b0);
    txn("lbu_21", 1'b0, 32'h21, 2'b00, 3'b100, 32'd0, 32'h00000080, 1'b0);
    txn("lw_20", 1'b0, 32'h20, 2'b00, 3'b010, 32'd0, 32'h00008000, 1'b0);
    txn("sh_22", 1'b1, 32'h22, 2'b01, 3'b000, 32'hAAAA8123, 32'd0, 1'b0);
    txn("lw_20b", 1'b0, 32'h20, 2'b00, 3'b010, 32'd0, 32'h81238000, 1'b0);
    txn("lh_22", 1'b0, 32'h22, 2'b00, 3'b001, 32'd0, 32'hFFFF8123, 1'b0);
    txn("lhu_22", 1'b0, 32'h22, 2'b00, 3'b101, 32'd0, 32'h00008123, 1'b0);
    txn("lh_20", 1'b0, 32'h20, 2'b00, 3'b001, 32'd0, 32'hFFFF8000, 1'b0);

    txn("lh_03", 1'b0, 32'h03, 2'b00, 3'b001, 32'd0, 32'd0, 1'b1);
    txn("sw_04", 1'b1, 32'h04, 2'b10, 3'b000, 32'h11223344, 32'd0, 1'b0);
    txn("sw_06_mis", 1'b1, 32'h06, 2'b10, 3'b000, 32'h1, 32'd0, 1'b1);
    txn("lw_04", 1'b0, 32'h04, 2'b00, 3'b010, 32'd0, 32'h11223344, 1'b0);

    txn("sw_00_clr", 1'b1, 32'h0, 2'b10, 3'b000, 32'd0, 32'd0, 1'b0);
    txn("sw_1000_oor", 1'b1, 32'h1000, 2'b10, 3'b000, 32'hCAFEF00D, 32'd0, 1'b1);
    txn("lw_00", 1'b0, 32'h0, 2'b00, 3'b010, 32'd0, 32'd0, 1'b0);
    txn("lw_1000_oor", 1'b0, 32'h1000, 2'b00, 3'b010, 32'd0, 32'd0, 1'b1);

    txn("sw_30", 1'b1, 32'h30, 2'b10, 3'b000, 32'h55, 32'd0, 1'b0);
    txn("st_ill", 1'b1, 32'h30, 2'b11, 3'b000, 32'hFFFFFFFF, 32'd0, 1'b1);
    txn("ld_ill3", 1'b0, 32'h30, 2'b00, 3'b011, 32'd0, 32'd0, 1'b1);
    txn("ld_ill7", 1'b0, 32'h30, 2'b00, 3'b111, 32'd0, 32'd0, 1'b1);
    txn("lw_30", 1'b0, 32'h30, 2'b00, 3'b010, 32'd0, 32'h55, 1'b0);

    // Stalled response, ignored requests while not ready, then same-cycle handover.
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(1'b0, 32'h10, 2'b00, 3'b010, 32'd0);
    req_valid = 1'b1;
    @(posedge clk);
    #1 set_req(1'b1, 32'h0, 2'b10, 3'b000, 32'h77);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_rdata", rsp_rdata, 32'hDEADBEEF);
      check("stall_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    set_req(1'b0, 32'h20, 2'b00, 3'b010, 32'd0);
    #1 check("release_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("b2b_valid", {31'd0, rsp_valid}, 32'd1);
    check("b2b_rdata", rsp_rdata, 32'h81238000);
    txn("lw_00_ign", 1'b0, 32'h0, 2'b00, 3'b010, 32'd0, 32'd0, 1'b0);

    // RD_LAT=2 instance: store, then load, each seen two cycles after accept.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (k == 0) set_req(1'b1, 32'h8, 2'b10, 3'b000, 32'hA5A5A5A5);
      else        set_req(1'b0, 32'h8, 2'b00, 3'b010, 32'd0);
      req_valid2 = 1'b1;
      @(posedge clk);
      #1 req_valid2 = 1'b0;
      @(negedge clk);
      check("lat2_wait_valid", {31'd0, rsp_valid2}, 32'd0);
      check("lat2_wait_ready", {31'd0, req_ready2}, 32'd0);
      @(negedge clk);
      check("lat2_valid", {31'd0, rsp_valid2}, 32'd1);
      check("lat2_rdata", rsp_rdata2, (k == 0) ? 32'd0 : 32'hA5A5A5A5);
      check("lat2_err", {31'd0, rsp_err2}, 32'd0);
    end

    // Reset pulsed in WAIT drops the response but keeps the committed store.
    @(negedge clk);
    set_req(1'b1, 32'hC, 2'b10, 3'b000, 32'h3C3C3C3C);
    req_valid2 = 1'b1;
    @(posedge clk);
    #1 req_valid2 = 1'b0;
    @(negedge clk);
    rst2_n = 1'b0;
    #1 check("wait_rst_valid", {31'd0, rsp_valid2}, 32'd0);
    check("wait_rst_ready", {31'd0, req_ready2}, 32'd0);
    @(negedge clk);
    rst2_n = 1'b1;
    #1 check("wait_rst_idle", {31'd0, req_ready2}, 32'd1);
    repeat (2) begin
      @(negedge clk);
      check("wait_rst_drop", {31'd0, rsp_valid2}, 32'd0);
    end
    set_req(1'b0, 32'hC, 2'b00, 3'b010, 32'd0);
    req_valid2 = 1'b1;
    @(posedge clk);
    #1 req_valid2 = 1'b0;
    repeat (2) @(negedge clk);
    check("lat2_kept_valid", {31'd0, rsp_valid2}, 32'd1);
    check("lat2_kept_rdata", rsp_rdata2, 32'h3C3C3C3C);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_pipelined.md
DMEM_PIPELINED -- requirements
Module: dmem_pipelined

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width; memory depth is 2**ADDR_W 32-bit words.
REQ-002 SHALL have parameter RD_LAT, default 1, response latency in cycles after acceptance; legal values are 1 and 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  block can accept a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_store_type  input  2  00 SB, 01 SH, 10 SW, 11 illegal.
REQ-010 SHALL have port req_load_type  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; all other codes are illegal.
REQ-011 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-012 SHALL have port rsp_valid  output  1  response present.
REQ-013 SHALL have port rsp_ready  input  1  consumer accepts the response.
REQ-014 SHALL have port rsp_rdata  output  32  load result, extended; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  output  1  access faulted (misaligned, out of range or illegal type).

Function
REQ-016 SHALL accept a request on a rising edge where req_valid && req_ready; at most one request is outstanding.
REQ-017 SHALL implement FSM states IDLE, WAIT and RESP.
  - IDLE -> WAIT on accept when RD_LAT=2.
  - IDLE -> RESP on accept when RD_LAT=1.
  - WAIT -> RESP after 1 cycle.
  - RESP -> IDLE on rsp_ready with no new accept.
  - RESP -> RESP/WAIT on rsp_ready with a simultaneous accept.
REQ-018 SHALL drive req_ready = (state==IDLE) || (state==RESP && rsp_ready), allowing back-to-back throughput of 1 request per RD_LAT+0 cycles at RD_LAT=1.
REQ-019 SHALL assert rsp_valid exactly RD_LAT cycles after the accepting edge and hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready is high.
REQ-020 SHALL commit store bytes to memory on the accepting edge, with byte lanes as follows.
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes.
REQ-021 SHALL sample the addressed memory word on the accepting edge, so a load accepted after a store to the same word returns the stored data.
REQ-022 SHALL extract loads at byte offset addr[1:0] (LH/LHU at addr[1]*16); LB/LH sign-extend, LBU/LHU zero-extend, LW returns the word.
REQ-023 SHALL flag a misaligned access: halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-024 SHALL flag an out-of-range access: addr[31:ADDR_W+2] nonzero.
REQ-025 SHALL flag an illegal type code per REQ-009/REQ-010.
REQ-026 SHALL, for any flagged access, suppress the memory write, return rsp_err=1 and rsp_rdata=0.
REQ-027 SHALL return rsp_rdata=0 and rsp_err=0 for a successful store (write acknowledge).
REQ-028 SHALL ignore req_* inputs when req_ready=0; no memory change occurs.

Reset
REQ-029 SHALL, while rst_n=0, force state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0.
REQ-030 SHALL assert req_ready=1 on the first cycle after rst_n deasserts.
REQ-031 SHALL NOT reset memory contents; they are zero-initialised at time 0 only.
REQ-032 SHALL, on reset during WAIT or RESP, discard the pending response; a store already accepted remains committed.

Structure
REQ-033 SHALL place the store_type and load_type encodings and the FSM state encoding in a shared package (dmem_pkg).
REQ-034 SHALL contain one sub-module, dmem_lane_align, a combinational store byte-strobe/align and load extract/extend unit.

Verification
REQ-035 SHALL cover SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-036 SHALL cover SB 0x80 @0x21, then LB @0x21 -> 0xFFFFFF80; LBU @0x21 -> 0x00000080; LW @0x20 -> 0x00008000.
REQ-037 SHALL cover LH @0x03 -> rsp_err=1, rsp_rdata=0; SW 0x1 @0x06 -> rsp_err=1 and a subsequent LW @0x04 is unchanged.
REQ-038 SHALL cover, with ADDR_W=10, SW @0x1000 -> rsp_err=1 and no aliasing write to @0x0.
REQ-039 SHALL cover rsp_ready held low 5 cycles -> rsp_valid/rsp_rdata stable and req_ready=0; on release, a back-to-back accept in the same cycle is accepted.
REQ-040 SHALL cover RD_LAT=2 -> rsp_valid 2 cycles after accept; rst_n pulsed in WAIT -> rsp_valid=0 and state IDLE next cycle.
